jtframe_serjoy: RTL

//  Polls up to PLAYERS daisy-chained parallel-in/serial-out joystick shift

---
 rtl/jtframe_serjoy.sv | 77 +++++++
 1 files changed

// File: rtl/jtframe_serjoy.sv
// jtframe_serjoy: polls a daisy-chained PISO joystick chain (DB15 SNAC) and
// presents per-player button vectors, one complete frame per poll.
module jtframe_serjoy #(
  parameter int PLAYERS = 2,
  parameter int BITS    = 12,
  parameter int DIV     = 16,
  parameter int LOAD_W  = 2,
  parameter bit INV     = 1'b1
) (
  input  logic                      clk_sys,
  input  logic                      RESET,
  input  logic [2:0]                nplayers,
  input  logic                      joy_data,
  output logic                      joy_clk,
  output logic                      joy_load,
  output logic [PLAYERS*BITS-1:0]   joy_out,
  output logic                      frame_done,
  output logic                      active
);
  localparam int W  = PLAYERS*BITS;
  localparam int NW = $clog2(W+1);
  localparam int CW = $clog2(DIV);
  localparam int KW = $clog2(W+LOAD_W+1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} st_t;
  st_t st_q, st_d;
  logic [CW-1:0] cnt_q;
  logic [KW-1:0] k_q;
  logic [NW-1:0] n_q;
  logic [W-1:0]  sr_q, out_q, mask;
  logic [1:0]    sy_q;
  logic [2:0]    np;
  logic clk_q, fd_q, act_q, en, tick, load_end, shift_end;
  assign en        = nplayers != 3'd0;
  assign np        = nplayers > 3'(PLAYERS) ? 3'(PLAYERS) : nplayers;
  assign tick      = cnt_q == CW'(DIV-1);
  assign load_end  = tick && k_q == KW'(LOAD_W-1);
  assign shift_end = tick && !clk_q && k_q == KW'(n_q) - 1'b1;
  // samples enter at the top, so after N of them the first one sits at W-N
  assign mask      = {W{1'b1}} >> (W - int'(n_q));
  always_ff @(posedge clk_sys or posedge RESET)
    if (RESET) st_q <= IDLE;
    else st_q <= st_d;
  always_comb
    st_d = !en ? IDLE :
           st_q == IDLE  ? LOAD :
           st_q == LOAD  ? (load_end ? SHIFT : LOAD) :
           st_q == SHIFT ? (shift_end ? DONE : SHIFT) : IDLE;
  always_comb begin
    joy_load   = st_q != LOAD;
    joy_clk    = clk_q;
    frame_done = fd_q;
    active     = act_q;
    joy_out    = out_q;
  end
  always_ff @(posedge clk_sys or posedge RESET)
    if (RESET) begin
      sy_q  <= '0;
      cnt_q <= '0;
      k_q   <= '0;
      n_q   <= '0;
      sr_q  <= '0;
      out_q <= '0;
      clk_q <= 1'b1;
      fd_q  <= 1'b0;
      act_q <= 1'b0;
    end else begin
      sy_q  <= {sy_q[0], joy_data};
      act_q <= en;
      fd_q  <= en && st_q == DONE;
      cnt_q <= st_q == IDLE || tick ? '0 : cnt_q + 1'b1;
      k_q   <= st_d != st_q ? '0 : tick && (st_q == LOAD || !clk_q) ? k_q + 1'b1 : k_q;
      clk_q <= st_q != SHIFT || !en ? 1'b1 : tick ? !clk_q : clk_q;
      if (st_q == SHIFT && tick && clk_q) sr_q <= (sr_q >> 1) | (W'(sy_q[1]) << (W-1));
      if (st_q == IDLE) n_q <= NW'(np * BITS);
      out_q <= !en ? '0 : st_q == DONE ? ((sr_q >> (W - int'(n_q))) ^ {W{INV}}) & mask : out_q;
    end
endmodule
